// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe: the master drives operands and
// out_ready, and the slave (the adder) returns in_ready and the registered result.
interface adder_pipe_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             c_in;
   logic             sub;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] S;
   logic             c_out;
   logic             ovf;
   logic             zero;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output A, B, c_in, sub, in_valid, out_ready,
      input  in_ready, S, c_out, ovf, zero, out_valid
   );

   modport slave (
      input  A, B, c_in, sub, in_valid, out_ready,
      output in_ready, S, c_out, ovf, zero, out_valid
   );
endinterface

// File: rtl/adder_pipe.sv
// Segmented ripple-carry add/subtract pipeline: each stage adds SEG_W bits and hands
// its carry forward; the whole pipe stalls as one when the output is not accepted.
module adder_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEG_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   adder_pipe_if.slave bus
);
   localparam int unsigned STAGES = (SEG_W != 0) ? WIDTH / SEG_W : 1;
   localparam int unsigned LAST   = STAGES - 1;

   if ((SEG_W == 0) || (SEG_W > WIDTH) || ((WIDTH % ((SEG_W == 0) ? 1 : SEG_W)) != 0))
   begin : g_bad_params
      $error("adder_pipe: SEG_W must be in 1..WIDTH and divide WIDTH");
   end

   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   logic             r_v [STAGES];
   logic             r_ovf;

   logic [WIDTH-1:0] w_a     [STAGES];
   logic [WIDTH-1:0] w_b     [STAGES];
   logic [WIDTH-1:0] w_s_in  [STAGES];
   logic [WIDTH-1:0] w_s_nxt [STAGES];
   logic             w_c_in  [STAGES];
   logic             w_c_nxt [STAGES];
   logic             w_v_in  [STAGES];
   logic [SEG_W:0]   w_seg;
   logic             w_adv;
   logic             w_ovf;

   function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] a,
                                              input logic [SEG_W-1:0] b,
                                              input logic             c);
      return {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, c};
   endfunction

   always_comb begin
      w_adv     = !r_v[LAST] || bus.out_ready;
      // Subtraction folds into addition: invert B and flip the incoming borrow.
      w_a[0]    = bus.A;
      w_b[0]    = bus.B ^ {WIDTH{bus.sub}};
      w_s_in[0] = '0;
      w_c_in[0] = bus.c_in ^ bus.sub;
      w_v_in[0] = bus.in_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
         w_a[i]    = r_a[i-1];
         w_b[i]    = r_b[i-1];
         w_s_in[i] = r_s[i-1];
         w_c_in[i] = r_c[i-1];
         w_v_in[i] = r_v[i-1];
      end
      w_seg = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         w_seg                          = seg_add(w_a[i][i*SEG_W +: SEG_W],
                                                  w_b[i][i*SEG_W +: SEG_W], w_c_in[i]);
         w_s_nxt[i]                     = w_s_in[i];
         w_s_nxt[i][i*SEG_W +: SEG_W]   = w_seg[SEG_W-1:0];
         w_c_nxt[i]                     = w_seg[SEG_W];
      end
      // Carry into the MSB is recovered as a^b^s of that bit, avoiding a separate tap.
      w_ovf = w_c_nxt[LAST] ^ w_a[LAST][WIDTH-1] ^ w_b[LAST][WIDTH-1] ^ w_s_nxt[LAST][WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
            r_s[i] <= '0;
            r_c[i] <= 1'b0;
            r_v[i] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            r_a[i] <= w_a[i];
            r_b[i] <= w_b[i];
            r_s[i] <= w_s_nxt[i];
            r_c[i] <= w_c_nxt[i];
            r_v[i] <= w_v_in[i];
         end
         r_ovf <= w_ovf;
      end
   end

   assign bus.in_ready  = w_adv && !reset;
   assign bus.S         = r_s[LAST];
   assign bus.c_out     = r_c[LAST];
   assign bus.ovf       = r_ovf;
   assign bus.out_valid = r_v[LAST];
   // Qualified by valid so that the cleared result after reset does not read as zero.
   assign bus.zero      = r_v[LAST] && (r_s[LAST] == '0);
endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe (WIDTH=8, SEG_W=4, two stages).
module tb_adder_pipe;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned SEG_W = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   adder_pipe_if #(.WIDTH(WIDTH)) bus ();

   adder_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stream vectors: A, B, c_in, sub
   logic [7:0] st_a   [10] = '{8'h12, 8'hF0, 8'h9C, 8'h00, 8'h7F, 8'hAB, 8'h55, 8'h01, 8'hC3, 8'h80};
   logic [7:0] st_b   [10] = '{8'h34, 8'h0F, 8'h64, 8'h00, 8'h80, 8'hCD, 8'hAA, 8'hFF, 8'h3C, 8'h80};
   logic       st_ci  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic       st_sub [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns {zero, ovf, c_out, S}; overflow taken from the 7-bit partial sum carry.
   function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic s);
      logic [7:0] be;
      logic       ce;
      logic [8:0] full;
      logic [7:0] low;
      be   = b ^ {8{s}};
      ce   = ci ^ s;
      full = {1'b0, a} + {1'b0, be} + {8'b0, ce};
      low  = {1'b0, a[6:0]} + {1'b0, be[6:0]} + {7'b0, ce};
      return {(full[7:0] == 8'h00), low[7] ^ full[8], full[8], full[7:0]};
   endfunction

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic s, input logic v);
      bus.A        = a;
      bus.B        = b;
      bus.c_in     = ci;
      bus.sub      = s;
      bus.in_valid = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] observed();
      return {bus.zero, bus.ovf, bus.c_out, bus.S};
   endfunction

   // Single isolated op; exp_f = {ovf, c_out, zero}
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic s, input logic [7:0] exp_s,
                         input logic [2:0] exp_f);
      drive(a, b, ci, s, 1'b1);
      tick();
      check_eq({tag, "_lat"}, bus.out_valid, 1'b0);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      check_eq({tag, "_vld"}, bus.out_valid, 1'b1);
      check_eq({tag, "_S"}, bus.S, exp_s);
      check_eq({tag, "_flags"}, {bus.ovf, bus.c_out, bus.zero}, exp_f);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      check_eq("rst_vld", bus.out_valid, 1'b0);
      check_eq("rst_S", bus.S, 8'h00);
      check_eq("rst_flags", {bus.ovf, bus.c_out, bus.zero}, 3'b000);
      check_eq("rst_in_ready", bus.in_ready, 1'b0);
      reset = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      check_eq("in_ready_after_rst", bus.in_ready, 1'b1);

      run_op("add_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 3'b000);
      run_op("wrap_zero", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 3'b011);
      run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 3'b100);
      run_op("add_cin",   8'h3A, 8'h45, 1'b1, 1'b0, 8'h80, 3'b100);
      run_op("sub_neg",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 3'b000);
      run_op("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 3'b110);
      run_op("sub_bin",   8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 3'b010);
      run_op("sub_eq",    8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 3'b011);

      // Back-to-back stream
      for (int c = 0; c <= 10; c++) begin
         if (c < 10) drive(st_a[c], st_b[c], st_ci[c], st_sub[c], 1'b1);
         else        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
         check_eq($sformatf("stream_rdy%0d", c), bus.in_ready, 1'b1);
         tick();
         if (c == 0) begin
            check_eq("stream_fill", bus.out_valid, 1'b0);
         end else begin
            check_eq($sformatf("stream_vld%0d", c - 1), bus.out_valid, 1'b1);
            check_eq($sformatf("stream_res%0d", c - 1), observed(),
                     model(st_a[c-1], st_b[c-1], st_ci[c-1], st_sub[c-1]));
         end
      end
      tick();
      check_eq("stream_drain", bus.out_valid, 1'b0);

      // Backpressure with the pipeline full
      drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
      tick();
      drive(8'h40, 8'h40, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("bp_full_vld", bus.out_valid, 1'b1);
      check_eq("bp_full_S", bus.S, 8'h33);
      bus.out_ready = 1'b0;
      drive(8'h10, 8'h20, 1'b1, 1'b1, 1'b1);
      #1;
      check_eq("bp_in_ready", bus.in_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq($sformatf("bp_hold_vld%0d", k), bus.out_valid, 1'b1);
         check_eq($sformatf("bp_hold_S%0d", k), bus.S, 8'h33);
         check_eq($sformatf("bp_hold_flags%0d", k), {bus.ovf, bus.c_out, bus.zero}, 3'b000);
         check_eq($sformatf("bp_hold_rdy%0d", k), bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      #1;
      check_eq("bp_resume_rdy", bus.in_ready, 1'b1);
      tick();
      check_eq("bp_res1_S", bus.S, 8'h80);
      check_eq("bp_res1_flags", {bus.ovf, bus.c_out, bus.zero}, 3'b100);
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      check_eq("bp_res2_vld", bus.out_valid, 1'b1);
      check_eq("bp_res2_S", bus.S, 8'hEF);
      check_eq("bp_res2_flags", {bus.ovf, bus.c_out, bus.zero}, 3'b000);
      tick();
      check_eq("bp_empty", bus.out_valid, 1'b0);

      // Reset with two operations in flight
      drive(8'h21, 8'h13, 1'b0, 1'b0, 1'b1);
      tick();
      drive(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("mid_pre_vld", bus.out_valid, 1'b1);
      check_eq("mid_pre_S", bus.S, 8'h34);
      reset = 1'b1;
      drive(8'h44, 8'h44, 1'b0, 1'b0, 1'b1);
      #1;
      check_eq("mid_rst_rdy", bus.in_ready, 1'b0);
      tick();
      check_eq("mid_rst_vld", bus.out_valid, 1'b0);
      check_eq("mid_rst_S", bus.S, 8'h00);
      check_eq("mid_rst_flags", {bus.ovf, bus.c_out, bus.zero}, 3'b000);
      reset = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq($sformatf("mid_no_stale%0d", k), bus.out_valid, 1'b0);
      end
      run_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits.
REQ-002 Parameter SEG_W, default 4: bits added per pipeline stage; WIDTH % SEG_W == 0 and 1 <= SEG_W <= WIDTH are mandatory, with elaboration error otherwise.
REQ-003 Derived STAGES = WIDTH/SEG_W: pipeline depth and latency in cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 c_in  input  1  carry-in in add mode, borrow-in in subtract mode.
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 in_valid  input  1  A/B/c_in/sub valid this cycle.
REQ-011 in_ready  output  1  block can accept an operation this cycle.
REQ-012 S  output  WIDTH  registered sum/difference.
REQ-013 c_out  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  S == 0.
REQ-016 out_valid  output  1  S/c_out/ovf/zero valid.
REQ-017 out_ready  input  1  downstream accepts result this cycle.

Function
REQ-018 Effective operands: Be = B XOR {WIDTH{sub}}, ce = c_in XOR sub; result = A + Be + ce, mod 2^WIDTH.
REQ-019 Add mode: S = A + B + c_in; subtract mode: S = A - B - c_in.
REQ-020 c_out is the raw carry out of bit WIDTH-1 of A + Be + ce in both modes.
REQ-021 ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 zero is derived from the final-stage S register, never from an earlier stage.
REQ-023 Stage i (0..STAGES-1) adds bits [i*SEG_W +: SEG_W] with carry from stage i-1 (stage 0 uses ce); each stage registers completed low segments, its carry, the unprocessed upper operand bits, and a valid bit.
REQ-024 Accept: an operation is captured at a rising edge where in_valid && in_ready && !reset.
REQ-025 Latency: an operation accepted at edge k is presented with out_valid=1 after edge k+STAGES-1 (STAGES=1: valid immediately after acceptance edge).
REQ-026 Throughput: one operation per cycle when out_ready is held high.
REQ-027 Stall: advance = !out_valid || out_ready; in_ready = advance && !reset; when advance=0 every stage register holds its value.
REQ-028 No bubble collapse: a stall freezes the whole pipeline even if internal stages are empty.
REQ-029 Outputs are held stable while out_valid && !out_ready.
REQ-030 Simultaneous output handshake and input acceptance with pipeline full: the result retires, all stages shift, and the new operation enters stage 0 in the same edge.
REQ-031 Results leave in acceptance order; none dropped or duplicated.
REQ-032 A cycle with in_valid=0 and advance=1 inserts a bubble, i.e. stage 0 valid=0.

Reset
REQ-033 When reset is high at a rising edge, all stage valid bits clear and S=0, c_out=0, ovf=0, zero=0, out_valid=0.
REQ-034 in_ready is 0 in any cycle reset is high; no input is captured.
REQ-035 Reset mid-operation discards all in-flight operations; none appears after reset deasserts.
REQ-036 The first operation accepted after reset behaves per REQ-025.

Verification (WIDTH=8, SEG_W=4, STAGES=2, out_ready=1 unless stated)
REQ-037 Add with inter-segment carry: A=0x0F, B=0x01, c_in=0, sub=0 -> two cycles later S=0x10, c_out=0, ovf=0, zero=0.
REQ-038 Wrap and zero: A=0xFF, B=0x01, c_in=0, sub=0 -> S=0x00, c_out=1, ovf=0, zero=1; separately A=0x7F, B=0x01 -> S=0x80, ovf=1, c_out=0.
REQ-039 Subtract:
- A=0x05, B=0x07, c_in=0, sub=1 -> S=0xFE, c_out=0, ovf=0.
- A=0x80, B=0x01, c_in=0, sub=1 -> S=0x7F, c_out=1, ovf=1.
- A=0x05, B=0x02, c_in=1, sub=1 -> S=0x02, c_out=1.
REQ-040 Back-to-back stream of 10 random operations, one per cycle -> 10 results in order, out_valid continuous after a 2-cycle fill, each matching the REQ-018 reference model.
REQ-041 Backpressure: out_ready=0 for 3 cycles with pipeline full -> in_ready=0, S and flags held constant; out_ready=1 -> results resume in order, none lost.
REQ-042 Reset mid-stream with 2 operations in flight -> out_valid=0 the next cycle, outputs zero, and no stale result afterwards; next accepted op (0x01+0x02) -> S=0x03 two cycles later.
